// File: rtl/sync_rx.sv
// Frame-sync / sample-clock receiver: brings the external sync/spclk pair into mclk,
// aligns frames, and reports lock, errors and spclk loss. SYNC_RX_PERIOD_MEAS_EN adds spclk_period.
module sync_rx #(
  parameter int SP_PER_FRAME  = 512,
  parameter int IDX_NBIT      = 9,
  parameter int MISS_MAX      = 8,
  parameter int SPCLK_TIMEOUT = 1200
) (
  input  logic                mclk,
  input  logic                rst,
  input  logic                sync_i,
  input  logic                spclk_i,
  output logic                sp_stb,
  output logic                frame_stb,
  output logic [IDX_NBIT-1:0] sp_idx,
  output logic                locked,
  output logic                frame_err,
  output logic                timeout,
  output logic [15:0]         frame_cnt,
  output logic [7:0]          err_cnt,
  output logic [15:0]         spclk_period
);

  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  localparam logic [IDX_NBIT-1:0] IDX_LAST = IDX_NBIT'(SP_PER_FRAME - 1);
  localparam logic [3:0]          MISS_LIM = 4'(MISS_MAX);
  localparam logic [15:0]         WD_LIM   = 16'(SPCLK_TIMEOUT);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        spclk_s1, spclk_s2, spclk_s3;
  logic        sync_s1, sync_s2;
  logic [0:0]  state;
  logic        sync_last;
  logic [3:0]  miss_cnt;
  logic [15:0] wd_cnt;
  logic [15:0] wd_nxt;
  logic        vld_p0;
  logic        sync_p0;
  logic        rise_p0;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      spclk_s1 <= 1'b0;
      spclk_s2 <= 1'b0;
      spclk_s3 <= 1'b0;
      sync_s1  <= 1'b0;
      sync_s2  <= 1'b0;
    end else begin
      spclk_s1 <= spclk_i;
      spclk_s2 <= spclk_s1;
      spclk_s3 <= spclk_s2;
      sync_s1  <= sync_i;
      sync_s2  <= sync_s1;
    end
  end

  // p0: falling spclk edge detected; sync is taken from the same cycle
  assign vld_p0  = spclk_s3 & ~spclk_s2;
  assign sync_p0 = sync_s2;
  assign rise_p0 = sync_p0 & ~sync_last;
  assign wd_nxt  = sat_inc16(wd_cnt);
  assign locked  = state;

  // p1: registered strobes, index, counters and lock state
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state     <= ST_HUNT;
      sync_last <= 1'b0;
      miss_cnt  <= 4'd0;
      wd_cnt    <= 16'd0;
      sp_stb    <= 1'b0;
      frame_stb <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
      sp_idx    <= '0;
      frame_cnt <= 16'd0;
      err_cnt   <= 8'd0;
    end else begin
      sp_stb    <= vld_p0;
      frame_stb <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
      if (vld_p0) begin
        wd_cnt    <= 16'd0;
        sync_last <= sync_p0;
        if (state == ST_HUNT) begin
          sp_idx <= '0;
          if (rise_p0) begin
            state     <= ST_LOCK;
            frame_stb <= 1'b1;
            frame_cnt <= 16'd0;
            miss_cnt  <= 4'd0;
          end
        end else if (rise_p0) begin
          // A sync away from the frame end is flagged, then the frame realigns to it
          if (sp_idx != IDX_LAST) begin
            frame_err <= 1'b1;
            err_cnt   <= sat_inc8(err_cnt);
          end
          sp_idx    <= '0;
          frame_stb <= 1'b1;
          frame_cnt <= frame_cnt + 16'd1;
          miss_cnt  <= 4'd0;
        end else if (sp_idx == IDX_LAST) begin
          sp_idx <= '0;
          if ((miss_cnt + 4'd1) == MISS_LIM) begin
            state <= ST_HUNT;
          end else begin
            frame_stb <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
            miss_cnt  <= miss_cnt + 4'd1;
          end
        end else begin
          sp_idx <= sp_idx + IDX_NBIT'(1);
        end
      end else begin
        wd_cnt <= wd_nxt;
        // The saturated counter never re-crosses the limit, so this fires once per loss
        if (wd_nxt == WD_LIM && wd_cnt != wd_nxt) begin
          timeout <= 1'b1;
          err_cnt <= sat_inc8(err_cnt);
          state   <= ST_HUNT;
          sp_idx  <= '0;
        end
      end
    end
  end

`ifdef SYNC_RX_PERIOD_MEAS_EN
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      spclk_period <= 16'd0;
    end else if (vld_p0) begin
      spclk_period <= wd_nxt;
    end
  end
`else
  assign spclk_period = 16'd0;
`endif

endmodule

// File: tb/tb_sync_rx.sv
// Randomized bench for sync_rx: spclk/sync stimulus with random timing, checked every
// mclk cycle against a sample-level frame model.
module tb_sync_rx;

  localparam int N   = 12;
  localparam int IW  = 4;
  localparam int MM  = 3;
  localparam int TMO = 200;
`ifdef SYNC_RX_PERIOD_MEAS_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  logic          mclk = 1'b0;
  logic          rst;
  logic          sync_i;
  logic          spclk_i;
  logic          sp_stb;
  logic          frame_stb;
  logic [IW-1:0] sp_idx;
  logic          locked;
  logic          frame_err;
  logic          timeout;
  logic [15:0]   frame_cnt;
  logic [7:0]    err_cnt;
  logic [15:0]   spclk_period;

  always #5 mclk = ~mclk;

  sync_rx #(
    .SP_PER_FRAME (N),
    .IDX_NBIT     (IW),
    .MISS_MAX     (MM),
    .SPCLK_TIMEOUT(TMO)
  ) dut (
    .mclk        (mclk),
    .rst         (rst),
    .sync_i      (sync_i),
    .spclk_i     (spclk_i),
    .sp_stb      (sp_stb),
    .frame_stb   (frame_stb),
    .sp_idx      (sp_idx),
    .locked      (locked),
    .frame_err   (frame_err),
    .timeout     (timeout),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt),
    .spclk_period(spclk_period)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int tick_n = 0;

  // Pending sample instants: tick at which the strobe is due, and the sync level at that sample
  int due_q[$];
  bit dsync_q[$];

  // Reference model state
  bit m_locked;
  bit m_prev;
  int m_idx, m_miss, m_fcnt, m_err, m_per;
  int last_stb, prev_stb;
  bit armed;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (tick %0d)", tag, got, exp, tick_n);
  endtask

  function automatic void model_reset();
    m_locked = 1'b0;
    m_prev   = 1'b0;
    m_idx    = 0;
    m_miss   = 0;
    m_fcnt   = 0;
    m_err    = 0;
    m_per    = 0;
    armed    = 1'b0;
    due_q.delete();
    dsync_q.delete();
  endfunction

  function automatic int sat255(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic tick();
    bit e_stb, e_fstb, e_ferr, e_to, s, rise;
    @(negedge mclk);
    tick_n++;
    e_stb = 0; e_fstb = 0; e_ferr = 0; e_to = 0;
    if (due_q.size() != 0 && due_q[0] == tick_n) begin
      void'(due_q.pop_front());
      s     = dsync_q.pop_front();
      e_stb = 1;
      rise  = s && !m_prev;
      m_prev = s;
      if (!m_locked) begin
        m_idx = 0;
        if (rise) begin
          m_locked = 1; e_fstb = 1; m_fcnt = 0; m_miss = 0;
        end
      end else if (rise) begin
        if (m_idx != N - 1) begin
          e_ferr = 1; m_err = sat255(m_err);
        end
        m_idx = 0; e_fstb = 1; m_fcnt++; m_miss = 0;
      end else if (m_idx == N - 1) begin
        m_idx = 0;
        m_miss++;
        if (m_miss >= MM) m_locked = 0;
        else begin
          e_fstb = 1; m_fcnt++;
        end
      end else begin
        m_idx++;
      end
      m_per    = tick_n - prev_stb;
      prev_stb = tick_n;
      last_stb = tick_n;
      armed    = 1;
    end else if (armed && (tick_n - last_stb) == TMO) begin
      e_to = 1; armed = 0; m_err = sat255(m_err); m_locked = 0; m_idx = 0;
    end
    chk("outputs", {sp_stb, frame_stb, frame_err, timeout, locked, sp_idx, frame_cnt, err_cnt},
        {e_stb, e_fstb, e_ferr, e_to, m_locked, IW'(m_idx), 16'(m_fcnt), 8'(m_err)});
    if (e_stb) chk("spclk_period", 64'(spclk_period), PER_EN ? 64'(m_per) : 64'd0);
  endtask

  task automatic send_sample(input bit s);
    int h, l;
    h = $urandom_range(4, 12);
    l = $urandom_range(4, 12);
    sync_i  = s;
    spclk_i = 1'b1;
    repeat (h) tick();
    spclk_i = 1'b0;
    due_q.push_back(tick_n + 3);
    dsync_q.push_back(s);
    repeat (l) tick();
  endtask

  // One frame of samples; sync is high for the first 'hold' samples (0 = omitted)
  task automatic send_frame(input int hold);
    for (int p = 0; p < N; p++) send_sample(p < hold);
  endtask

  task automatic release_rst();
    rst      = 1'b0;
    last_stb = tick_n;
    prev_stb = tick_n;
    armed    = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_immediate", {sp_stb, frame_stb, frame_err, timeout, locked, sp_idx, frame_cnt, err_cnt,
        spclk_period}, 64'd0);
    model_reset();
    repeat (2) tick();
    release_rst();
  endtask

  initial begin
    rst     = 1'b1;
    sync_i  = 1'b0;
    spclk_i = 1'b0;
    model_reset();
    repeat (3) tick();
    release_rst();

    // Nominal framing, then a short frame
    repeat (4) send_frame(1);
    for (int p = 0; p < 7; p++) send_sample(1'b0);
    repeat (2) send_frame(1);

    // Flywheel through fewer than MISS_MAX missing syncs, then lose lock
    repeat (MM - 1) send_frame(0);
    send_frame(1);
    repeat (MM) send_frame(0);
    repeat (2) send_frame(1);

    // Sync held high across several samples counts once
    repeat (2) send_frame(3);

    // spclk stops: one timeout only, then relock
    repeat (TMO + 60) tick();
    repeat (2) send_frame(1);

    // Reset mid-frame, no lock until a fresh sync rising
    send_frame(1);
    for (int p = 0; p < 5; p++) send_sample(1'b0);
    do_reset();
    for (int p = 0; p < 3; p++) send_sample(1'b0);
    repeat (2) send_frame(1);

    // Random sync pattern with occasional stray syncs
    for (int f = 0; f < 15; f++) begin
      for (int p = 0; p < N; p++)
        send_sample((p == 0 && $urandom_range(0, 3) != 0) || ($urandom_range(0, 29) == 0));
    end
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_rx.md
# sync_rx

Frame-sync / sample-clock receiver for the ADC acquisition path. It takes the asynchronous external IN_SYNC and IN_SPCLK pair, the same signalling format our board emits on OUT_SYNC/OUT_SPCLK, and brings it into the mclk domain. It produces a per-sample strobe, sample index, frame strobe and lock/error status. It sits between the board input pins and the acquisition cache/command decoder, and validates frame structure before data is trusted.

## Interface
Parameters:
- SP_PER_FRAME, 512, samples per frame (≥2).
- IDX_NBIT, 9, width of sp_idx; 2^IDX_NBIT ≥ SP_PER_FRAME.
- MISS_MAX, 8, consecutive missing syncs tolerated before lock is dropped (1..15).
- SPCLK_TIMEOUT, 1200, mclk cycles without a spclk falling edge before timeout (≤65535).

Ports:
- Clock and reset: one clock, mclk; asynchronous, active-high reset, rst.
- mclk  in  1  system clock, 120 MHz.
- rst  in  1  asynchronous, active-high reset.
- sync_i  in  1  raw frame sync, asynchronous to mclk.
- spclk_i  in  1  raw sample clock (nominal 200 kHz), asynchronous.
- sp_stb  out  1  one-cycle pulse per accepted sample instant.
- frame_stb  out  1  one-cycle pulse, coincident with sp_stb when sp_idx==0.
- sp_idx  out  IDX_NBIT  index of the current sample within the frame.
- locked  out  1  frame alignment valid.
- frame_err  out  1  one-cycle pulse: sync arrived at the wrong index.
- timeout  out  1  one-cycle pulse: spclk lost.
- frame_cnt  out  16  frames started since lock; wraps.
- err_cnt  out  8  frame_err plus timeout events; saturates at 255.
- spclk_period  out  16  measured spclk period in mclk cycles; present only with the macro, see Configuration.

## Operation
- Input capture: sync_i and spclk_i each pass through two flops (s1, s2), then a third history flop (s3). A falling edge is s3=1 & s2=0. The sampling instant is the spclk falling edge, which is mid-period. Sync transitions coincide with spclk rising edges, so sampling sync on the falling edge is race-free. The sync value used is the sync s2 captured on the same cycle as the edge.
- State machine, two states:
  - ST_HUNT: sp_stb still pulses on every edge. sp_idx holds 0. locked=0.
  - ST_HUNT exit: an edge with sync=1 where the previous edge had sync=0 → ST_LOCK. sp_idx=0, frame_stb=1, frame_cnt=0, miss count cleared.
  - ST_LOCK, edge with sync rising and sp_idx==SP_PER_FRAME-1: sp_idx=0, frame_stb=1, frame_cnt+1, miss count cleared.
  - ST_LOCK, edge with sync rising at any other index: frame_err=1, err_cnt+1. Then realign: sp_idx=0, frame_stb=1, frame_cnt+1, miss count cleared. Remain in ST_LOCK.
  - ST_LOCK, edge with sp_idx==SP_PER_FRAME-1 and no sync rising (flywheel): sp_idx=0, frame_stb=1, frame_cnt+1, miss count+1.
  - ST_LOCK, miss count reaching MISS_MAX: go to ST_HUNT on that edge and emit no frame_stb.
  - ST_LOCK, any other edge: sp_idx+1.
- A sync held high across several edges counts as one rising event only.
- Watchdog: a 16-bit counter clears on every spclk falling edge and otherwise increments, saturating.
  - On reaching SPCLK_TIMEOUT: timeout=1 for one cycle, err_cnt+1, state → ST_HUNT, sp_idx=0.
  - Timeout fires once per loss. It re-arms only after the next edge.
- Simultaneous events: an edge and a timeout cannot coincide, because the edge clears the counter first. Edge processing has priority.

## Timing
- Latency: an edge on spclk_i first sampled low at mclk edge k gives sp_stb/frame_stb/sp_idx high or valid in the cycle after edge k+2. That is 3 mclk cycles.
- sp_idx, locked, frame_cnt and err_cnt update in the same cycle as sp_stb, and are stable until the next strobe.
- All outputs are registered.
- Reset values: sp_stb=0, frame_stb=0, sp_idx=0, locked=0, frame_err=0, timeout=0, frame_cnt=0, err_cnt=0, spclk_period=0. Synchronizer flops reset to 0; the watchdog counter resets to 0; the state resets to ST_HUNT.
- Reset mid-frame: everything returns to the reset values immediately. Lock requires a fresh sync rising.
- The minimum spclk high or low width is 3 mclk cycles; narrower pulses may be lost.

## Configuration
- SYNC_RX_PERIOD_MEAS_EN defined: on each spclk falling edge, spclk_period loads the watchdog count from the previous edge (cycles between edges). The first edge after reset loads the count since reset.
- SYNC_RX_PERIOD_MEAS_EN undefined: spclk_period is tied to 0 and the measurement register is not built.

## Test plan
- Nominal: spclk 600-cycle period, sync high for 1 sample every 512 samples, 3 frames → locked=1 after the first sync. frame_stb every 512 sp_stb, sp_idx 0..511, frame_cnt=2 after the third sync, err_cnt=0.
- Short frame: sync at sample 300 while locked → frame_err pulse, err_cnt=1, sp_idx restarts at 0, locked stays 1.
- Flywheel (superframe gap): 5 consecutive syncs omitted → locked stays 1 and frame_stb continues every 512 samples. With 8 omitted → locked=0 on the 8th missing boundary.
- spclk stopped low for 1300 cycles → timeout pulse at 1200 cycles after the last edge, err_cnt+1, locked=0; no second pulse until spclk resumes.
- rst asserted at sp_idx=200 → all outputs 0 in the same cycle. After release, no lock until the next sync rising.
- With SYNC_RX_PERIOD_MEAS_EN, spclk period 600 → spclk_period=600 from the second edge onward. Without the macro → spclk_period=0 throughout.
